// File: rtl/maple_pkg.sv
// Shared Maple receive definitions: FSM encoding,
// parameter legality checks and beat constants.
package maple_pkg;

  localparam int S_IDLE  = 0;
  localparam int S_PH1   = 1;
  localparam int S_PH2   = 2;
  localparam int S_FLUSH = 3;

  localparam logic [3:0] ST_IDLE  = 4'b0001;
  localparam logic [3:0] ST_PH1   = 4'b0010;
  localparam logic [3:0] ST_PH2   = 4'b0100;
  localparam logic [3:0] ST_FLUSH = 4'b1000;

  localparam logic [3:0] NULL_KEEP = 4'b0000;

  function automatic bit data_bytes_ok(int n);
    return (n == 1) || (n == 2) || (n == 4);
  endfunction

  function automatic bit fifo_depth_ok(int d);
    return (d >= 4) && ((d & (d - 1)) == 0);
  endfunction

endpackage

// File: rtl/maple_axis_fifo.sv
// Synchronous beat FIFO with occupancy count; read data
// is forced to zero while empty so idle outputs stay clean.
module maple_axis_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  output logic [AW:0]   occupancy,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          do_wr;
  logic          do_rd;
  logic          full;

  assign full      = count[AW];
  assign rd_valid  = |count;
  assign do_rd     = rd_valid & rd_ready;
  assign do_wr     = wr_en & (~full | do_rd);
  assign occupancy = count;
  assign rd_data   = rd_valid ? mem[rptr] : '0;

  always_ff @(posedge aclk) begin
    if (do_wr) begin
      mem[wptr] <= wr_data;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) begin
        wptr <= wptr + 1'b1;
      end
      if (do_rd) begin
        rptr <= rptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/maple_rx_stream_decoder.sv
// Maple Bus two-phase receive decoder producing AXI4-Stream
// beats with per-lane keep, frame counting and error pulses.
module maple_rx_stream_decoder
  import maple_pkg::*;
#(
  parameter int DATA_BYTES = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 12
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    enable,
  input  logic                    sdcka_data,
  input  logic                    sdcka_posedge,
  input  logic                    sdcka_negedge,
  input  logic                    sdckb_data,
  input  logic                    sdckb_posedge,
  input  logic                    sdckb_negedge,
  output logic [8*DATA_BYTES-1:0] m_tdata,
  output logic [DATA_BYTES-1:0]   m_tkeep,
  output logic [DATA_BYTES-1:0]   m_tstrb,
  output logic                    m_tlast,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [CNT_W-1:0]        frame_bytes,
  output logic                    frame_done,
  output logic                    frame_error,
  output logic                    overflow
);

  localparam int DW = 8 * DATA_BYTES;
  localparam int LW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int OW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = DW + DATA_BYTES + 1;

  localparam logic [LW-1:0] LANE_LAST = LW'(DATA_BYTES - 1);
  localparam logic [OW-1:0] OCC_FULL  = OW'(FIFO_DEPTH);
  localparam logic [OW-1:0] OCC_RSV   = OW'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (!data_bytes_ok(DATA_BYTES) || !fifo_depth_ok(FIFO_DEPTH))
  begin : g_bad_param
    $error("maple_rx_stream_decoder: illegal parameters");
  end

  typedef enum logic [3:0] {
    IDLE   = ST_IDLE,
    PHASE1 = ST_PH1,
    PHASE2 = ST_PH2,
    FLUSH  = ST_FLUSH
  } state_t;

  state_t                state;
  logic [6:0]            sh;
  logic [2:0]            bit_cnt;
  logic [LW-1:0]         lane;
  logic [DW-1:0]         word;
  logic [DATA_BYTES-1:0] keep;
  logic [CNT_W-1:0]      byte_cnt;

  logic                  push_vld;
  logic [DW-1:0]         push_data;
  logic [DATA_BYTES-1:0] push_keep;
  logic                  push_last;

  logic                  edge_hit;
  logic                  bit_in;
  logic                  closing;
  logic                  byte_done;
  logic                  word_full;
  logic [7:0]            byte_nxt;
  logic [DW-1:0]         word_nxt;
  logic [DATA_BYTES-1:0] keep_nxt;

  logic [OW-1:0]         occ;
  logic                  pop;
  logic                  room;
  logic                  wr_en;
  logic [FW-1:0]         fifo_rd;
  logic                  unused_ok;

  assign unused_ok = &{1'b0, sdcka_posedge, sdckb_posedge};

  // Only the edge of the expected phase is accepted, and never
  // while enable is low (that cycle belongs to frame close).
  always_comb begin
    edge_hit = 1'b0;
    bit_in   = 1'b0;
    unique case (1'b1)
      state[S_IDLE], state[S_PH1]: begin
        edge_hit = enable & sdcka_negedge;
        bit_in   = sdckb_data;
      end
      state[S_PH2]: begin
        edge_hit = enable & sdckb_negedge;
        bit_in   = sdcka_data;
      end
      default: begin
        edge_hit = 1'b0;
        bit_in   = 1'b0;
      end
    endcase
  end

  assign closing   = ~enable & (state[S_PH1] | state[S_PH2]);
  assign byte_nxt  = {sh, bit_in};
  assign byte_done = edge_hit & (bit_cnt == 3'd7);
  assign word_full = byte_done & (lane == LANE_LAST);

  always_comb begin
    word_nxt = word;
    keep_nxt = keep;
    if (byte_done) begin
      word_nxt[8*int'(lane) +: 8] = byte_nxt;
      keep_nxt[lane]              = 1'b1;
    end
  end

  assign pop   = m_tvalid & m_tready;
  assign room  = push_last ? ((occ < OCC_FULL) | pop)
                           : (occ < OCC_RSV);
  assign wr_en = push_vld & room;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state       <= IDLE;
      sh          <= '0;
      bit_cnt     <= '0;
      lane        <= '0;
      word        <= '0;
      keep        <= '0;
      byte_cnt    <= '0;
      push_vld    <= 1'b0;
      push_data   <= '0;
      push_keep   <= '0;
      push_last   <= 1'b0;
      frame_bytes <= '0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      push_vld    <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      overflow    <= push_vld & ~room;

      if (edge_hit) begin
        if (bit_cnt == 3'd7) begin
          sh      <= '0;
          bit_cnt <= '0;
          if (byte_cnt != CNT_MAX) begin
            byte_cnt <= byte_cnt + 1'b1;
          end
          if (word_full) begin
            push_vld  <= 1'b1;
            push_data <= word_nxt;
            push_keep <= '1;
            push_last <= 1'b0;
            word      <= '0;
            keep      <= '0;
            lane      <= '0;
          end else begin
            word <= word_nxt;
            keep <= keep_nxt;
            lane <= lane + 1'b1;
          end
        end else begin
          sh      <= {sh[5:0], bit_in};
          bit_cnt <= bit_cnt + 1'b1;
        end
      end

      unique case (1'b1)
        state[S_IDLE]: begin
          if (enable) begin
            state <= edge_hit ? PHASE2 : PHASE1;
          end
        end
        state[S_PH1]: begin
          if (edge_hit) begin
            state <= PHASE2;
          end
        end
        state[S_PH2]: begin
          if (edge_hit) begin
            state <= PHASE1;
          end
        end
        state[S_FLUSH]: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // Close the frame: the tlast beat is written during FLUSH,
      // alongside the frame_done and frame_error pulses.
      if (closing) begin
        state       <= FLUSH;
        push_vld    <= 1'b1;
        push_data   <= word;
        push_keep   <= (|keep) ? keep
                                : NULL_KEEP[DATA_BYTES-1:0];
        push_last   <= 1'b1;
        frame_done  <= 1'b1;
        frame_error <= (bit_cnt != 3'd0);
        frame_bytes <= byte_cnt;
        sh          <= '0;
        bit_cnt     <= '0;
        lane        <= '0;
        word        <= '0;
        keep        <= '0;
        byte_cnt    <= '0;
      end
    end
  end

  maple_axis_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .aclk      (aclk),
    .areset    (areset),
    .wr_en     (wr_en),
    .wr_data   ({push_data, push_keep, push_last}),
    .occupancy (occ),
    .rd_valid  (m_tvalid),
    .rd_ready  (m_tready),
    .rd_data   (fifo_rd)
  );

  assign {m_tdata, m_tkeep, m_tlast} = fifo_rd;
  assign m_tstrb = m_tkeep;

endmodule

// File: tb/tb_maple_rx_stream_decoder.sv
// Directed bench for maple_rx_stream_decoder with a beat
// scoreboard filled at stimulus time and drained on handshakes.
module tb_maple_rx_stream_decoder;

  localparam int DB = 4;
  localparam int FD = 4;
  localparam int CW = 12;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          enable = 1'b0;
  logic          sdcka_data = 1'b0;
  logic          sdcka_posedge = 1'b0;
  logic          sdcka_negedge = 1'b0;
  logic          sdckb_data = 1'b0;
  logic          sdckb_posedge = 1'b0;
  logic          sdckb_negedge = 1'b0;
  logic          m_tready = 1'b1;
  logic [31:0]   m_tdata;
  logic [3:0]    m_tkeep;
  logic [3:0]    m_tstrb;
  logic          m_tlast;
  logic          m_tvalid;
  logic [CW-1:0] frame_bytes;
  logic          frame_done;
  logic          frame_error;
  logic          overflow;

  always #5 aclk = ~aclk;

  maple_rx_stream_decoder #(
    .DATA_BYTES (DB),
    .FIFO_DEPTH (FD),
    .CNT_W      (CW)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .enable        (enable),
    .sdcka_data    (sdcka_data),
    .sdcka_posedge (sdcka_posedge),
    .sdcka_negedge (sdcka_negedge),
    .sdckb_data    (sdckb_data),
    .sdckb_posedge (sdckb_posedge),
    .sdckb_negedge (sdckb_negedge),
    .m_tdata       (m_tdata),
    .m_tkeep       (m_tkeep),
    .m_tstrb       (m_tstrb),
    .m_tlast       (m_tlast),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready),
    .frame_bytes   (frame_bytes),
    .frame_done    (frame_done),
    .frame_error   (frame_error),
    .overflow      (overflow)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  typedef logic [7:0] bq_t[$];

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_ovf = 0;
  int    n_ferr = 0;
  int    n_fdone = 0;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge aclk) begin
    if (!areset) begin
      if (overflow)    n_ovf++;
      if (frame_error) n_ferr++;
      if (frame_done)  n_fdone++;
      if (m_tvalid && m_tready) begin
        beat_t e;
        n_cmp++;
        assert (exp_q.size() > 0) else begin
          n_bad++;
          $error("FAIL beat_extra observed=%h expected=none",
                 {m_tdata, m_tkeep, m_tlast});
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_cmp++;
          assert ({m_tdata, m_tkeep, m_tstrb, m_tlast} ===
                  {e.d, e.k, e.k, e.l}) else begin
            n_bad++;
            $error("FAIL beat observed=%h/%h/%h/%b expected=%h/%h/%b",
                   m_tdata, m_tkeep, m_tstrb, m_tlast,
                   e.d, e.k, e.l);
          end
        end
      end
    end
  end

  function automatic void expect_frame(bq_t b, int keep_words);
    beat_t e;
    int    w;
    e = '0;
    w = 0;
    foreach (b[i]) begin
      e.d[8*(i%4) +: 8] = b[i];
      e.k[i%4]          = 1'b1;
      if (i % 4 == 3) begin
        if (w < keep_words) exp_q.push_back(e);
        w++;
        e = '0;
      end
    end
    e.l = 1'b1;
    exp_q.push_back(e);
  endfunction

  task automatic cyc(int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic send_frame(bq_t b, int xbits, bit coinc,
                            bit wrong, int lat_bit, bit no_end);
    int nb;
    bit v;
    nb = b.size() * 8 + xbits;
    if (!coinc) begin
      enable = 1'b1;
      cyc(1);
    end
    for (int i = 0; i < nb; i++) begin
      if (i < b.size() * 8) v = b[i/8][7-(i%8)];
      else                  v = (i % 2 == 1);
      enable = 1'b1;
      if (i % 2 == 0) begin
        sdckb_data    = v;
        sdcka_negedge = 1'b1;
      end else begin
        sdcka_data    = v;
        sdckb_negedge = 1'b1;
      end
      cyc(1);
      sdcka_negedge = 1'b0;
      sdckb_negedge = 1'b0;
      if (i == lat_bit) chk("lat_t1", m_tvalid, 0);
      cyc(1);
      if (i == lat_bit) chk("lat_t2", m_tvalid, 1);
      if (wrong && i == 1) begin
        sdcka_data    = ~sdcka_data;
        sdckb_negedge = 1'b1;
        cyc(1);
        sdckb_negedge = 1'b0;
        cyc(1);
      end
    end
    if (!no_end) begin
      enable = 1'b0;
      cyc(4);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) cyc(1);
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t b;
    int  d0;
    int  e0;
    int  o0;

    cyc(3);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_out", {m_tdata, m_tkeep, m_tstrb, m_tlast}, 0);
    chk("rst_pulses", {frame_done, frame_error, overflow}, 0);
    chk("rst_fbytes", frame_bytes, 0);
    areset = 1'b0;
    cyc(2);

    // 5-byte frame: one full word and a one-lane tlast beat
    b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    d0 = n_fdone; e0 = n_ferr;
    expect_frame(b, 1000);
    send_frame(b, 0, 0, 0, -1, 0);
    wait_drain();
    chk("f5_bytes", frame_bytes, 5);
    chk("f5_done", n_fdone - d0, 1);
    chk("f5_err", n_ferr - e0, 0);

    // exactly one word: full beat then null tlast beat
    b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    d0 = n_fdone;
    expect_frame(b, 1000);
    send_frame(b, 0, 0, 0, 31, 0);
    wait_drain();
    chk("f4_bytes", frame_bytes, 4);
    chk("f4_done", n_fdone - d0, 1);

    // two bytes plus three stray bits
    b = '{8'hAA, 8'hBB};
    e0 = n_ferr;
    expect_frame(b, 1000);
    send_frame(b, 3, 0, 0, -1, 0);
    wait_drain();
    chk("ferr_pulse", n_ferr - e0, 1);
    chk("ferr_bytes", frame_bytes, 2);

    // enable coincident with first edge, wrong-phase edge
    b = '{8'hA5};
    expect_frame(b, 1000);
    send_frame(b, 0, 1, 1, -1, 0);
    wait_drain();
    chk("coinc_bytes", frame_bytes, 1);

    // 6-word frame into a stalled 4-deep FIFO
    b = {};
    for (int i = 0; i < 24; i++) b.push_back(8'(i * 7 + 3));
    m_tready = 1'b0;
    o0 = n_ovf;
    expect_frame(b, 3);
    send_frame(b, 0, 0, 0, -1, 0);
    chk("ovf_pulses", n_ovf - o0, 3);
    chk("ovf_valid", m_tvalid, 1);
    cyc(3);
    chk("ovf_hold", m_tdata, exp_q[0].d);
    chk("ovf_bytes", frame_bytes, 24);
    m_tready = 1'b1;
    wait_drain();

    // reset mid-frame with two beats queued
    b = {};
    for (int i = 0; i < 9; i++) b.push_back(8'(8'hF0 - i));
    m_tready = 1'b0;
    send_frame(b, 0, 0, 0, -1, 1);
    chk("rst_mid_q", m_tvalid, 1);
    areset = 1'b1;
    cyc(1);
    exp_q.delete();
    chk("rst_mid_tvalid", m_tvalid, 0);
    chk("rst_mid_out", {m_tdata, m_tkeep, m_tlast}, 0);
    chk("rst_mid_misc",
        {frame_bytes, frame_done, frame_error, overflow}, 0);
    enable   = 1'b0;
    areset   = 1'b0;
    m_tready = 1'b1;
    cyc(2);

    // clean frame after the abort
    b = '{8'h5A, 8'hC3, 8'h3C};
    d0 = n_fdone;
    expect_frame(b, 1000);
    send_frame(b, 0, 0, 0, -1, 0);
    wait_drain();
    chk("post_bytes", frame_bytes, 3);
    chk("post_done", n_fdone - d0, 1);
    chk("ovf_total", n_ovf, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
